// File: rtl/alu_op_sequencer.sv
// Execute-stage sequencer for MCU51 ALU instructions: fetches the source operand
// (immediate, direct or @Ri), drives the external ALU, then writes ACC or RAM and PSW flags.
module alu_op_sequencer #(
    parameter int RAM_AW = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [1:0]        op_mode,
    input  logic              op_dst,
    input  logic [7:0]        op_arg,
    input  logic [7:0]        acc,
    input  logic              cy,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_re,
    input  logic [7:0]        ram_rdata,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    output logic [3:0]        alu_code,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic              alu_ci,
    input  logic [7:0]        alu_result,
    input  logic              alu_carry,
    input  logic              alu_ac,
    output logic              acc_we,
    output logic [7:0]        acc_wdata,
    output logic              psw_we,
    output logic              psw_cy,
    output logic              psw_ac,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_PTR_RD, S_PTR_WAIT, S_OPD_RD, S_OPD_WAIT, S_EXEC, S_WB, S_ERR
    } state_t;

    localparam logic [3:0] C_INC  = 4'b0000;
    localparam logic [3:0] C_DEC  = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_ADDC = 4'b0011;
    localparam logic [3:0] C_SUBB = 4'b1001;

    state_t             state_q, state_d;
    logic [3:0]         code_q, code_d;
    logic [1:0]         mode_q, mode_d;
    logic               dst_q, dst_d;
    logic [RAM_AW-1:0]  addr_q, addr_d;
    logic [7:0]         opnd_q, opnd_d;
    logic [7:0]         res_q, res_d;
    logic               carry_q, carry_d;
    logic               ac_q, ac_d;

    logic code_ok;
    logic legal;

    always_comb begin
        case (op_code)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9: code_ok = 1'b1;
            default:                                         code_ok = 1'b0;
        endcase
        legal = code_ok
             && !(op_mode == 2'b11 && op_code != C_INC && op_code != C_DEC)
             && !(op_dst && (op_mode == 2'b00 || op_mode == 2'b11));
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        mode_d  = mode_q;
        dst_d   = dst_q;
        addr_d  = addr_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        carry_d = carry_q;
        ac_d    = ac_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    code_d = op_code;
                    mode_d = op_mode;
                    dst_d  = op_dst;
                    opnd_d = op_arg;
                    // Direct address or Ri address; both are consumed through addr_q.
                    addr_d = op_arg[RAM_AW-1:0];
                    if (!legal)
                        state_d = S_ERR;
                    else if (op_mode == 2'b01)
                        state_d = S_OPD_RD;
                    else if (op_mode == 2'b10)
                        state_d = S_PTR_RD;
                    else
                        state_d = S_EXEC;
                end
            end
            S_PTR_RD:   state_d = S_PTR_WAIT;
            S_PTR_WAIT: begin
                addr_d  = ram_rdata[RAM_AW-1:0];
                state_d = S_OPD_RD;
            end
            S_OPD_RD:   state_d = S_OPD_WAIT;
            S_OPD_WAIT: begin
                opnd_d  = ram_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d   = alu_result;
                carry_d = alu_carry;
                ac_d    = alu_ac;
                state_d = S_WB;
            end
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            mode_q  <= '0;
            dst_q   <= 1'b0;
            addr_q  <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ac_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            mode_q  <= mode_d;
            dst_q   <= dst_d;
            addr_q  <= addr_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ac_q    <= ac_d;
        end
    end

    // Outputs decode only from registered state, so reset clears them immediately.
    always_comb begin
        op_ready  = (state_q == S_IDLE);
        ram_addr  = '0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        alu_code  = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_ci    = 1'b0;
        acc_we    = 1'b0;
        acc_wdata = '0;
        psw_we    = 1'b0;
        psw_cy    = 1'b0;
        psw_ac    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_PTR_RD, S_OPD_RD: begin
                ram_re   = 1'b1;
                ram_addr = addr_q;
            end
            S_EXEC: begin
                alu_code = code_q;
                alu_ci   = (code_q == C_ADDC || code_q == C_SUBB) ? cy : 1'b0;
                if (code_q == C_INC || code_q == C_DEC) begin
                    alu_a = (mode_q == 2'b11) ? acc : opnd_q;
                end else begin
                    alu_a = acc;
                    alu_b = opnd_q;
                end
            end
            S_WB: begin
                done = 1'b1;
                if (dst_q) begin
                    ram_we    = 1'b1;
                    ram_addr  = addr_q;
                    ram_wdata = res_q;
                end else begin
                    acc_we    = 1'b1;
                    acc_wdata = res_q;
                end
                if (code_q == C_ADD || code_q == C_ADDC) begin
                    psw_we = 1'b1;
                    psw_cy = carry_q;
                    psw_ac = ac_q;
                end else if (code_q == C_SUBB) begin
                    // ALU reports no-borrow; PSW stores borrow.
                    psw_we = 1'b1;
                    psw_cy = ~carry_q;
                    psw_ac = ~ac_q;
                end
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

endmodule
